// File: rtl/seg7_scroll_mux.sv
// seg7_scroll_mux: scrolls a NUM_DIGITS-wide window of a writable character buffer
// across a multiplexed common-anode seven-segment display, manually or on a timer.
module seg7_scroll_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_DEPTH   = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int AUTO_DIV    = 50000000,
    localparam int AW = $clog2(MSG_DEPTH)
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [4:0]            wr_data,
    input  logic [AW:0]           msg_len,
    input  logic                  step,
    input  logic                  mode,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [AW-1:0]         pos
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int TW = $clog2(AUTO_DIV);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = AW + 4;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h4F, 7'h2F, 7'h55, 7'h3F, 7'h7F};

    logic [4:0]    mem [MSG_DEPTH];
    logic [RW-1:0] ref_cnt;
    logic [TW-1:0] auto_cnt;
    logic [DW-1:0] d;
    logic          step_q;
    logic [AW:0]   len_eff;
    logic          adv;
    logic          blank;
    logic [SW-1:0] k;
    logic [SW-1:0] idx_raw;
    logic [AW-1:0] rd_addr;
    logic [4:0]    entry;

    always_comb begin
        len_eff = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
        adv     = mode ? (auto_cnt == TW'(AUTO_DIV - 1)) : (step & ~step_q);
        k       = SW'(NUM_DIGITS - 1) - SW'(d);
        idx_raw = SW'(pos) + k;
        // pos + k < 2*len_eff whenever the digit is not blank, so one subtract suffices
        rd_addr = AW'((idx_raw >= SW'(len_eff)) ? idx_raw - SW'(len_eff) : idx_raw);
        blank   = k >= SW'(len_eff);
        entry   = blank ? 5'h0F : mem[rd_addr];
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= 5'h0F;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ref_cnt  <= '0;
            d        <= '0;
            auto_cnt <= '0;
            step_q   <= 1'b1;
            pos      <= '0;
        end else begin
            ref_cnt  <= (ref_cnt == RW'(REFRESH_DIV - 1)) ? '0 : ref_cnt + RW'(1);
            if (ref_cnt == RW'(REFRESH_DIV - 1))
                d <= (d == DW'(NUM_DIGITS - 1)) ? '0 : d + DW'(1);
            auto_cnt <= (!mode || auto_cnt == TW'(AUTO_DIV - 1)) ? '0 : auto_cnt + TW'(1);
            step_q   <= step;
            if (len_eff == '0 || {1'b0, pos} >= len_eff)
                pos <= '0;
            else if (adv)
                pos <= ({1'b0, pos} + (AW+1)'(1) == len_eff) ? '0 : pos + AW'(1);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << d);
            seg <= GLYPH[entry[3:0]];
            dp  <= ~entry[4];
        end
    end
endmodule

// File: tb/tb_seg7_scroll_mux.sv
// tb_seg7_scroll_mux: randomized self-checking bench comparing the scroller against a
// behavioural model of the message buffer, window pointer and display frame.
module tb_seg7_scroll_mux;
    localparam int ND = 4, MD = 16, RD = 4, AD = 8;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h4F, 7'h2F, 7'h55, 7'h3F, 7'h7F};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [4:0]    wr_data = '0;
    logic [4:0]    msg_len = '0;
    logic          step = 1'b0;
    logic          mode = 1'b0;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    pos;

    logic [4:0] m_mem [MD];
    int         m_pos, m_len;
    logic [6:0] got_seg [ND];
    logic       got_dp [ND];
    int         errors = 0, checks = 0;

    seg7_scroll_mux #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .REFRESH_DIV(RD), .AUTO_DIV(AD)) dut (
        .CLOCK(clk), .RESET(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .step(step), .mode(mode), .an(an), .seg(seg), .dp(dp), .pos(pos)
    );

    always #5 clk = ~clk;

    function automatic int len_eff();
        return m_len > MD ? MD : m_len;
    endfunction

    function automatic logic [6:0] exp_seg(int k);
        int l = len_eff();
        if (k >= l) return 7'h7F;
        return GLYPH[m_mem[(m_pos + k) % l][3:0]];
    endfunction

    function automatic logic exp_dp(int k);
        int l = len_eff();
        if (k >= l) return 1'b1;
        return ~m_mem[(m_pos + k) % l][4];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MD; i++) m_mem[i] = 5'h0F;
        m_pos = 0;
    endtask

    task automatic advance();
        if (len_eff() > 0) m_pos = (m_pos + 1) % len_eff();
    endtask

    task automatic write_entry(int a, logic [4:0] v);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
        m_mem[a] = v;
    endtask

    task automatic set_len(int l);
        msg_len = 5'(l);
        m_len = l;
        if (m_pos >= len_eff()) m_pos = 0;
        @(negedge clk);
    endtask

    task automatic do_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        advance();
        @(negedge clk);
    endtask

    // Records what each window offset shows over one full frame; index = offset from the left.
    task automatic capture_frame();
        for (int k = 0; k < ND; k++) begin got_seg[k] = 'x; got_dp[k] = 1'bx; end
        repeat (ND * RD) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++)
                if (an == ~(ND'(1) << d)) begin got_seg[ND-1-d] = seg; got_dp[ND-1-d] = dp; end
        end
    endtask

    task automatic test_reset();
        set_len(5);
        write_entry(0, 5'd3);
        write_entry(1, 5'd4);
        do_step();
        repeat (3) @(negedge clk);
        step = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        checks++; if (pos !== 4'd0) begin errors++; $display("FAIL reset_pos got=%0d exp=0", pos); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ND * RD; i++) begin
            @(negedge clk);
            checks++;
            if (an !== ~(ND'(1) << (i / RD))) begin
                errors++; $display("FAIL reset_scan cycle=%0d got=%b exp=%b", i, an, ~(ND'(1) << (i / RD)));
            end
        end
        checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL reset_step_held got=%0d exp=%0d", pos, m_pos); end
        step = 1'b0;
        @(negedge clk);
        capture_frame();
        for (int k = 0; k < ND; k++) begin
            checks++;
            if (got_seg[k] !== exp_seg(k) || got_dp[k] !== exp_dp(k)) begin
                errors++; $display("FAIL reset_blank k=%0d got=%h/%b exp=%h/%b", k, got_seg[k], got_dp[k], exp_seg(k), exp_dp(k));
            end
        end
    endtask

    task automatic test_name_scroll();
        write_entry(0, 5'd13);
        write_entry(1, 5'd11);
        write_entry(2, 5'd12);
        write_entry(3, 5'd10);
        write_entry(4, 5'h1E);
        set_len(5);
        for (int s = 0; s < 2; s++) begin
            capture_frame();
            for (int k = 0; k < ND; k++) begin
                checks++;
                if (got_seg[k] !== exp_seg(k) || got_dp[k] !== exp_dp(k)) begin
                    errors++; $display("FAIL name_frame step=%0d k=%0d got=%h/%b exp=%h/%b", s, k, got_seg[k], got_dp[k], exp_seg(k), exp_dp(k));
                end
            end
            do_step();
        end
        repeat (3) do_step();
        checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL name_wrap got=%0d exp=%0d", pos, m_pos); end
    endtask

    task automatic test_short();
        write_entry(0, 5'd1);
        write_entry(1, 5'd2);
        set_len(2);
        for (int s = 0; s < 2; s++) begin
            capture_frame();
            for (int k = 0; k < ND; k++) begin
                checks++;
                if (got_seg[k] !== exp_seg(k) || got_dp[k] !== exp_dp(k)) begin
                    errors++; $display("FAIL short_frame step=%0d k=%0d got=%h/%b exp=%h/%b", s, k, got_seg[k], got_dp[k], exp_seg(k), exp_dp(k));
                end
            end
            do_step();
        end
    endtask

    task automatic test_step_hold();
        set_len(5);
        step = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        advance();
        @(negedge clk);
        checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL step_hold got=%0d exp=%0d", pos, m_pos); end
    endtask

    task automatic test_auto();
        set_len(16);
        mode = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i % AD == 0) advance();
            checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL auto_run cycle=%0d got=%0d exp=%0d", i, pos, m_pos); end
        end
        step = 1'b0;
        @(negedge clk);
        mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL auto_stop cycle=%0d got=%0d exp=%0d", i, pos, m_pos); end
        end
        mode = 1'b1;
        for (int i = 1; i <= AD; i++) begin
            @(negedge clk);
            if (i == AD) advance();
            checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL auto_restart cycle=%0d got=%0d exp=%0d", i, pos, m_pos); end
        end
        mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_shrink();
        set_len(5);
        for (int i = 0; i < 5 && m_pos != 4; i++) do_step();
        checks++; if (pos !== 4'd4) begin errors++; $display("FAIL shrink_setup got=%0d exp=4", pos); end
        set_len(3);
        checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL shrink_pos got=%0d exp=%0d", pos, m_pos); end
        set_len(0);
        do_step();
        checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL empty_pos got=%0d exp=%0d", pos, m_pos); end
        capture_frame();
        for (int k = 0; k < ND; k++) begin
            checks++;
            if (got_seg[k] !== exp_seg(k) || got_dp[k] !== exp_dp(k)) begin
                errors++; $display("FAIL empty_frame k=%0d got=%h/%b exp=%h/%b", k, got_seg[k], got_dp[k], exp_seg(k), exp_dp(k));
            end
        end
        for (int a = 0; a < MD; a++) write_entry(a, 5'($urandom));
        set_len(MD + 1);
        repeat (MD + 1) do_step();
        checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL clamp_pos got=%0d exp=%0d", pos, m_pos); end
        capture_frame();
        for (int k = 0; k < ND; k++) begin
            checks++;
            if (got_seg[k] !== exp_seg(k) || got_dp[k] !== exp_dp(k)) begin
                errors++; $display("FAIL clamp_frame k=%0d got=%h/%b exp=%h/%b", k, got_seg[k], got_dp[k], exp_seg(k), exp_dp(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        int np;
        logic [4:0] v;
        set_len(5);
        np = (m_pos + 1) % 5;
        v = 5'($urandom);
        step = 1'b1; wr_en = 1'b1; wr_addr = 4'(np); wr_data = v;
        @(negedge clk);
        step = 1'b0; wr_en = 1'b0;
        m_mem[np] = v;
        advance();
        @(negedge clk);
        checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL b2b_pos got=%0d exp=%0d", pos, m_pos); end
        capture_frame();
        for (int k = 0; k < ND; k++) begin
            checks++;
            if (got_seg[k] !== exp_seg(k) || got_dp[k] !== exp_dp(k)) begin
                errors++; $display("FAIL b2b_frame k=%0d got=%h/%b exp=%h/%b", k, got_seg[k], got_dp[k], exp_seg(k), exp_dp(k));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            repeat (3) write_entry($urandom_range(0, MD - 1), 5'($urandom));
            set_len($urandom_range(0, MD + 1));
            repeat ($urandom_range(0, 3)) do_step();
            checks++; if (pos !== 4'(m_pos)) begin errors++; $display("FAIL rand_pos it=%0d got=%0d exp=%0d", it, pos, m_pos); end
            capture_frame();
            for (int k = 0; k < ND; k++) begin
                checks++;
                if (got_seg[k] !== exp_seg(k) || got_dp[k] !== exp_dp(k)) begin
                    errors++; $display("FAIL rand_frame it=%0d len=%0d k=%0d got=%h/%b exp=%h/%b", it, m_len, k, got_seg[k], got_dp[k], exp_seg(k), exp_dp(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        m_len = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_name_scroll();
        test_short();
        test_step_hold();
        test_auto();
        test_shrink();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scroll_mux.md
# seg7_scroll_mux

Parametrised multiplexed seven-segment message scroller. It holds a writable message buffer of character codes and time-multiplexes a NUM_DIGITS-wide window of that message onto a common-anode display. The window advances on a button step edge (manual mode) or on a fixed period (auto mode). It sits between the board's pushbutton/switch logic and the 7-segment pins. It supersedes the single-digit, button-clocked character sequencer.

## Interface
- NUM_DIGITS, 4, number of display digits (1..8)
- MSG_DEPTH, 16, message buffer entries (2..256, power of two); AW = clog2(MSG_DEPTH)
- REFRESH_DIV, 100000, CLOCK cycles each digit stays lit (>=2)
- AUTO_DIV, 50000000, CLOCK cycles per auto-mode advance (>=2)

- CLOCK  in  1  system clock; all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- wr_en  in  1  write message entry this cycle
- wr_addr  in  AW  entry index
- wr_data  in  5  {dp, code[3:0]}; dp=1 lights decimal point
- msg_len  in  AW+1  valid entries; values above MSG_DEPTH clamp to MSG_DEPTH (len_eff)
- step  in  1  synchronous level; rising edge advances in manual mode
- mode  in  1  0 = manual step, 1 = auto advance
- an  out  NUM_DIGITS  anodes, active low; an[NUM_DIGITS-1] = leftmost digit
- seg  out  7  {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- pos  out  AW  current window start pointer

## Operation
- Character codes (seg hex): 0..9 -> 40,79,24,30,19,12,02,78,00,10; 10 A -> 08; 11 I -> 4F; 12 r -> 2F; 13 W -> 55; 14 '-' -> 3F; 15 blank -> 7F.
- Buffer: MSG_DEPTH x 5 registers; reset to 5'b0_1111 (blank, dp off). Write lands on the edge where wr_en=1.
- Advance event: mode=0: step & ~step_q (step_q reset to 1, so step held high through reset is not an edge). mode=1: auto counter reaches AUTO_DIV-1, then returns to 0. Auto counter held at 0 while mode=0. Step edges are ignored in mode=1.
- Pointer update, in priority order:
  - len_eff == 0 or pos >= len_eff: pos <= 0.
  - Else, on an advance event: pos <= (pos+1 == len_eff) ? 0 : pos+1.
- Scanner: refresh counter 0..REFRESH_DIV-1. At the terminal count, digit index d advances and wraps NUM_DIGITS-1 -> 0.
- Digit d shows offset k = NUM_DIGITS-1-d:
  - k >= len_eff: blank (no repetition of short messages).
  - Else: entry[(pos+k) mod len_eff], with the mod computed as a single conditional subtract.
- Output register, updated every cycle from the current d, pos and buffer: an = ~(1<<d); seg = decode(code); dp = ~entry.dp.

## Timing
- Reset values:
  - an all ones; seg 7'h7F; dp 1; pos 0; d 0.
  - refresh counter 0; auto counter 0; step_q 1; buffer blank.
- First lit digit: an=~1 at the first edge after RESET deasserts.
- Step edge sampled at edge n -> pos updates at edge n -> seg/dp reflect it at edge n+1.
- Buffer write at edge n -> visible at edge n+1 if that entry is on the active digit.
- Each digit is lit for exactly REFRESH_DIV cycles. Full frame = NUM_DIGITS*REFRESH_DIV cycles.
- Auto mode: consecutive advances are exactly AUTO_DIV cycles apart.
- RESET mid-scan forces all outputs to reset values immediately (asynchronous). Buffer contents are lost.
- Write and advance in the same cycle: both take effect. The display uses the new pointer and the new data one cycle later.

## Test plan
- Reset: assert RESET mid-frame -> an=4'b1111, seg=7'h7F, dp=1, pos=0 without a clock edge. After release, an cycles 1110,1101,1011,0111 (REFRESH_DIV=4), each held 4 cycles.
- Name scroll: write W,I,r,A,'-'+dp (13,11,12,10,5'h1E), msg_len=5, NUM_DIGITS=4 -> leftmost-to-right shows 55,4F,2F,08. After one step edge: 4F,2F,08,3F with dp=0 on the rightmost digit. After 5 steps total: pos=0 (wrap).
- Short message: msg_len=2, codes 1,2 -> digits 79,24,7F,7F. A step gives 24,79,7F,7F.
- Step held high for 10 cycles -> exactly one advance. Step high across reset release -> no advance.
- Auto mode: AUTO_DIV=8, mode=1 -> pos increments every 8 cycles. Step edges ignored. Switching to mode=0 stops advances and clears the auto counter.
- Shrink: pos=4, msg_len changed 5->3 -> pos=0 next cycle. msg_len=0 -> all digits 7F, pos stays 0. msg_len=MSG_DEPTH+1 behaves as MSG_DEPTH.
